// File: rtl/pug_mdarb_pkg.sv
// Shared definitions for the two-requester RV32M muldiv arbiter: FSM states,
// funct3 codes and the default WAIT timeout.
package pug_mdarb_pkg;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_IDLE  = 2'd1,
      ST_ISSUE = 2'd2,
      ST_WAIT  = 2'd3
   } state_e;

   typedef enum logic [2:0] {
      FN_MUL    = 3'b000,
      FN_MULH   = 3'b001,
      FN_MULHSU = 3'b010,
      FN_MULHU  = 3'b011,
      FN_DIV    = 3'b100,
      FN_DIVU   = 3'b101,
      FN_REM    = 3'b110,
      FN_REMU   = 3'b111
   } fn3_e;

   localparam int TMO_DEFAULT = 63;

endpackage

// File: rtl/pug_rrarb.sv
// Two-way round-robin grant. On a tie the requester not granted last wins;
// the last-grant register only moves when the grant is actually taken.
module pug_rrarb (
   input  logic clk,
   input  logic rst,
   input  logic i_req0,
   input  logic i_req1,
   input  logic i_take,
   output logic o_gnt_any,
   output logic o_gnt_id
);

   logic r_last;
   logic w_gnt_id;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      w_gnt_id = 1'b0;
      if (i_req0 && i_req1) w_gnt_id = ~r_last;
      else                  w_gnt_id = i_req1;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         r_last <= 1'b1;
      else if (i_take) r_last <= w_gnt_id;
   end

   assign o_gnt_any = i_req0 | i_req1;
   assign o_gnt_id  = w_gnt_id;

endmodule

// File: rtl/pug_mdarb.sv
// Arbitrates two requesters onto one shared muldiv unit: CLEAR -> IDLE -> ISSUE -> WAIT,
// with a WAIT timeout that returns err=1 and rd=0.
module pug_mdarb
   import pug_mdarb_pkg::*;
#(
   parameter int TMO = TMO_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        req1,
   input  logic [2:0]  fn3_0,
   input  logic [2:0]  fn3_1,
   input  logic [31:0] a0,
   input  logic [31:0] b0,
   input  logic [31:0] a1,
   input  logic [31:0] b1,
   output logic        ack0,
   output logic        ack1,
   output logic [31:0] rd,
   output logic        err,
   output logic        md_go,
   output logic        md_rst,
   output logic [31:0] md_rs1,
   output logic [31:0] md_rs2,
   output logic [2:0]  md_fn3,
   input  logic        md_done,
   input  logic [31:0] md_rd
);

   localparam logic [7:0] L_TMO = 8'(TMO);

   state_e      r_state;
   state_e      w_next;
   logic [7:0]  r_cnt;
   logic        r_gnt;
   logic        r_ack0;
   logic        r_ack1;
   logic        r_err;
   logic [31:0] r_rd;
   logic [31:0] r_rs1;
   logic [31:0] r_rs2;
   logic [2:0]  r_fn3;
   logic        w_gnt_any;
   logic        w_gnt_id;
   logic        w_take;
   logic        w_fin;

   pug_rrarb u_rrarb (
      .clk       (clk),
      .rst       (rst),
      .i_req0    (req0),
      .i_req1    (req1),
      .i_take    (w_take),
      .o_gnt_any (w_gnt_any),
      .o_gnt_id  (w_gnt_id)
   );

   always_comb begin
      w_next = r_state;
      w_take = 1'b0;
      w_fin  = 1'b0;
      case (r_state)
         ST_CLEAR: w_next = ST_IDLE;
         ST_IDLE: begin
            if (w_gnt_any) begin
               w_take = 1'b1;
               w_next = ST_ISSUE;
            end
         end
         ST_ISSUE: w_next = ST_WAIT;
         ST_WAIT: begin
            // md_done wins over a timeout landing in the same cycle
            if (md_done || (r_cnt == L_TMO)) begin
               w_fin  = 1'b1;
               w_next = ST_CLEAR;
            end
         end
         default: w_next = ST_CLEAR;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_CLEAR;
         r_cnt   <= 8'd0;
         r_gnt   <= 1'b0;
         r_ack0  <= 1'b0;
         r_ack1  <= 1'b0;
         r_err   <= 1'b0;
         r_rd    <= 32'd0;
         r_rs1   <= 32'd0;
         r_rs2   <= 32'd0;
         r_fn3   <= 3'd0;
      end else begin
         r_state <= w_next;
         r_ack0  <= w_fin & ~r_gnt;
         r_ack1  <= w_fin &  r_gnt;
         if (w_take) begin
            r_gnt <= w_gnt_id;
            r_fn3 <= w_gnt_id ? fn3_1 : fn3_0;
            r_rs1 <= w_gnt_id ? a1 : a0;
            r_rs2 <= w_gnt_id ? b1 : b0;
         end
         if (r_state == ST_ISSUE)                r_cnt <= 8'd0;
         else if (r_state == ST_WAIT && !md_done) r_cnt <= r_cnt + 8'd1;
         if (w_fin) begin
            r_rd  <= md_done ? md_rd : 32'd0;
            r_err <= ~md_done;
         end
      end
   end

   // Strobes decode straight from the registered state, so they are glitch-free and exclusive.
   assign md_rst = (r_state == ST_CLEAR);
   assign md_go  = (r_state == ST_ISSUE);
   assign md_rs1 = r_rs1;
   assign md_rs2 = r_rs2;
   assign md_fn3 = r_fn3;
   assign ack0   = r_ack0;
   assign ack1   = r_ack1;
   assign rd     = r_rd;
   assign err    = r_err;

endmodule

// File: tb/tb_pug_mdarb.sv
// Directed bench for pug_mdarb with a behavioural RV32M unit of programmable latency.
module tb_pug_mdarb;

   localparam int TMO = 63;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0 = 1'b0, req1 = 1'b0;
   logic [2:0]  fn3_0 = 3'd0, fn3_1 = 3'd0;
   logic [31:0] a0 = 32'd0, b0 = 32'd0, a1 = 32'd0, b1 = 32'd0;
   logic        ack0, ack1, err, md_go, md_rst;
   logic [31:0] rd, md_rs1, md_rs2;
   logic [2:0]  md_fn3;
   logic        md_done = 1'b0;
   logic [31:0] md_rd = 32'd0;

   always #5 clk = ~clk;

   pug_mdarb #(.TMO(TMO)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .fn3_0(fn3_0), .fn3_1(fn3_1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .ack0(ack0), .ack1(ack1), .rd(rd), .err(err),
      .md_go(md_go), .md_rst(md_rst), .md_rs1(md_rs1), .md_rs2(md_rs2), .md_fn3(md_fn3),
      .md_done(md_done), .md_rd(md_rd)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // RV32M reference for the shared unit
   function automatic logic [31:0] muldiv(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] ps;
      logic        [63:0] pu;
      logic               ovf;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f)
         3'b000: return a * b;
         3'b001: begin ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return ps[63:32]; end
         3'b010: begin ps = $signed({{32{a[31]}}, a}) * $signed({32'd0, b}); return ps[63:32]; end
         3'b011: begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
         3'b100: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
         3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'b110: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   int unsigned lat   = 2;
   logic        stall = 1'b0;
   logic        m_busy = 1'b0;
   int unsigned m_cnt = 0;
   logic [31:0] m_res = 32'd0;

   always @(posedge clk) begin
      if (md_rst) begin
         m_busy  <= 1'b0;
         md_done <= 1'b0;
      end else if (md_go) begin
         m_busy <= 1'b1;
         m_cnt  <= lat;
         m_res  <= muldiv(md_fn3, md_rs1, md_rs2);
      end else if (m_busy && !stall) begin
         if (m_cnt == 0) begin
            md_done <= 1'b1;
            md_rd   <= m_res;
            m_busy  <= 1'b0;
         end else begin
            m_cnt <= m_cnt - 1;
         end
      end
   end

   // Protocol monitor: pulse counts, exclusivity, operand stability per operation
   int          go_cnt = 0, rst_cnt = 0, ack_cnt = 0, viol = 0, stab_bad = 0;
   logic        in_op = 1'b0;
   logic [66:0] exp_op = '0;

   initial forever begin
      @(negedge clk);
      if (md_go)  go_cnt++;
      if (md_rst) rst_cnt++;
      if (ack0 || ack1) ack_cnt++;
      if ((ack0 && ack1) || (md_go && md_rst) || ((ack0 || ack1) && !md_rst)) viol++;
      if (ack0 || ack1) begin
         check("operands_stable", 32'(stab_bad), 0);
         in_op    = 1'b0;
         stab_bad = 0;
      end else if (md_rst) begin
         in_op    = 1'b0;
         stab_bad = 0;
      end else begin
         if (md_go) in_op = 1'b1;
         if (in_op && ({md_fn3, md_rs1, md_rs2} !== exp_op)) stab_bad++;
      end
   end

   task automatic run_op(input int budget, output int id, output logic [31:0] r, output logic e,
                         output int lat_cyc);
      int go_at;
      go_at = -1; id = -1; r = '0; e = 1'b0; lat_cyc = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (md_go && go_at < 0) go_at = i;
         if (ack0 || ack1) begin
            id      = ack1 ? 1 : 0;
            r       = rd;
            e       = err;
            lat_cyc = i - go_at;
            if (ack0) req0 = 1'b0;
            if (ack1) req1 = 1'b0;
            return;
         end
      end
      check("ack_timeout", 1, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          id, lc, g0, r0, a_before;
      logic [31:0] r;
      logic        e, got_go;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_md_rst", 32'(md_rst), 1);
      check("rst_md_go", 32'(md_go), 0);
      check("rst_acks", 32'({ack0, ack1}), 0);
      check("rst_err", 32'(err), 0);
      check("rst_rd", rd, 0);
      check("rst_rs1", md_rs1, 0);
      check("rst_rs2", md_rs2, 0);
      check("rst_fn3", 32'(md_fn3), 0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk); check("post_rst_clear", 32'(md_rst), 1);
      @(negedge clk); check("post_rst_idle", 32'(md_rst), 0);

      // MUL 7*6
      g0 = go_cnt; r0 = rst_cnt;
      fn3_0 = 3'b000; a0 = 32'd7; b0 = 32'd6;
      exp_op = {3'b000, 32'd7, 32'd6};
      req0 = 1'b1;
      run_op(50, id, r, e, lc);
      check("mul_id", 32'(id), 0);
      check("mul_rd", r, 32'd42);
      check("mul_err", 32'(e), 0);
      check("mul_go_to_ack", 32'(lc), 5);
      @(negedge clk); check("ack_width", 32'(ack0), 0);
      repeat (2) @(negedge clk);
      check("mul_go_pulses", 32'(go_cnt - g0), 1);
      check("mul_rst_pulses", 32'(rst_cnt - r0), 1);

      // tie right after reset: requester 0 first
      @(negedge clk); rst = 1'b1;
      repeat (2) @(negedge clk);
      @(posedge clk); #1 rst = 1'b0;
      fn3_0 = 3'b100; a0 = 32'hFFFF_FFF9; b0 = 32'd2;
      fn3_1 = 3'b111; a1 = 32'd7;         b1 = 32'd0;
      exp_op = {3'b100, 32'hFFFF_FFF9, 32'd2};
      req0 = 1'b1; req1 = 1'b1;
      run_op(50, id, r, e, lc);
      check("tie_first_id", 32'(id), 0);
      check("div_rd", r, 32'hFFFF_FFFD);
      exp_op = {3'b111, 32'd7, 32'd0};
      run_op(50, id, r, e, lc);
      check("tie_second_id", 32'(id), 1);
      check("remu_rd", r, 32'd7);
      check("remu_err", 32'(e), 0);

      // both held, each re-raised after its ack: grants alternate
      fn3_0 = 3'b000; a0 = 32'd10; b0 = 32'd3;
      fn3_1 = 3'b000; a1 = 32'd5;  b1 = 32'd4;
      exp_op = {3'b000, 32'd10, 32'd3};
      req0 = 1'b1; req1 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         run_op(50, id, r, e, lc);
         check($sformatf("rr_id_%0d", k), 32'(id), 32'(k % 2));
         check($sformatf("rr_rd_%0d", k), r, (k % 2 == 0) ? 32'd30 : 32'd20);
         exp_op = (k % 2 == 0) ? {3'b000, 32'd5, 32'd4} : {3'b000, 32'd10, 32'd3};
         if (k == 3) begin
            req0 = 1'b0; req1 = 1'b0;
         end else begin
            @(negedge clk);
            if (id == 0) req0 = 1'b1;
            else         req1 = 1'b1;
         end
      end

      // md_done arriving exactly when the counter hits TMO wins
      lat = 62; a0 = 32'd3; b0 = 32'd5;
      exp_op = {3'b000, 32'd3, 32'd5};
      req0 = 1'b1;
      run_op(200, id, r, e, lc);
      check("edge_done_rd", r, 32'd15);
      check("edge_done_err", 32'(e), 0);
      check("edge_done_lat", 32'(lc), 65);
      // one cycle later the timeout fires first
      lat = 63; a0 = 32'd4; b0 = 32'd4;
      exp_op = {3'b000, 32'd4, 32'd4};
      req0 = 1'b1;
      run_op(200, id, r, e, lc);
      check("edge_tmo_rd", r, 32'd0);
      check("edge_tmo_err", 32'(e), 1);

      // unit never answers: timeout after 64 WAIT cycles, then recovery
      lat = 2; stall = 1'b1; a0 = 32'd9; b0 = 32'd9;
      exp_op = {3'b000, 32'd9, 32'd9};
      req0 = 1'b1;
      run_op(200, id, r, e, lc);
      check("tmo_id", 32'(id), 0);
      check("tmo_rd", r, 32'd0);
      check("tmo_err", 32'(e), 1);
      check("tmo_go_to_ack", 32'(lc), 65);
      check("tmo_md_rst", 32'(md_rst), 1);
      @(negedge clk);
      check("tmo_md_rst_done", 32'(md_rst), 0);
      stall = 1'b0; a1 = 32'd6; b1 = 32'd7;
      exp_op = {3'b000, 32'd6, 32'd7};
      req1 = 1'b1;
      run_op(50, id, r, e, lc);
      check("recover_id", 32'(id), 1);
      check("recover_rd", r, 32'd42);
      check("recover_err", 32'(e), 0);

      // asynchronous reset mid-WAIT aborts silently; reissue completes
      lat = 20; fn3_0 = 3'b101; a0 = 32'd100; b0 = 32'd7;
      exp_op = {3'b101, 32'd100, 32'd7};
      req0 = 1'b1;
      got_go = 1'b0;
      for (int i = 0; i < 50 && !got_go; i++) begin
         @(negedge clk);
         if (md_go) got_go = 1'b1;
      end
      check("abort_go_seen", 32'(got_go), 1);
      repeat (5) @(negedge clk);
      a_before = ack_cnt;
      #2 rst = 1'b1; req0 = 1'b0;
      #1;
      check("async_md_rst", 32'(md_rst), 1);
      check("async_md_go", 32'(md_go), 0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk); check("abort_clear_cycle", 32'(md_rst), 1);
      @(negedge clk); check("abort_idle", 32'(md_rst), 0);
      repeat (30) @(negedge clk);
      check("abort_no_ack", 32'(ack_cnt - a_before), 0);
      lat = 2;
      req0 = 1'b1;
      run_op(50, id, r, e, lc);
      check("divu_id", 32'(id), 0);
      check("divu_rd", r, 32'd14);
      check("divu_err", 32'(e), 0);

      repeat (3) @(negedge clk);
      check("protocol_violations", 32'(viol), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
